ro_puf_seq: RTL and testbench

Time-multiplexed, parametrised ring-oscillator PUF evaluator. It replaces per-RO counters with one counter pair that is shared across all RO pairs. The block walks pair indices 0..PAIRS-1 under an FSM and builds the response bit by bit. It sits between the placed RO array (instantiated outside, fed in as a bus) and the response consumer (UART/host logic).

---
 rtl/ro_puf_seq.sv | 183 ++++++++++++++++++
 tb/tb_ro_puf_seq.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/ro_puf_seq.sv
// ro_puf_seq: time-multiplexed ring-oscillator PUF evaluator.
// One shared counter pair measures each RO pair in turn (pair k compares
// ro_in[k] against ro_in[k+PAIRS]) and the response is built bit by bit.
// Optional build macro PUF_MAJORITY_EN: each pair is measured VOTES times
// and its response bit is the majority of the individual comparisons.
module ro_puf_seq #(
  parameter int PAIRS = 64,
  parameter int CNT_W = 24,
  parameter int WIN_W = 24,
  parameter int VOTES = 5,
  localparam int IDX_W = (PAIRS > 1) ? $clog2(PAIRS) : 1
) (
  input  logic                 clk_ref,
  input  logic                 rst,
  input  logic                 start,
  input  logic [2*PAIRS-1:0]   ro_in,
  input  logic [WIN_W-1:0]     window_cycles,
  output logic                 busy,
  output logic                 done,
  output logic [PAIRS-1:0]     puf_response,
  output logic [IDX_W-1:0]     pair_idx
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_COUNT, S_COMPARE, S_FIN
  } state_t;

  state_t             state_reg, state_next;
  logic               start_accept;
  logic [WIN_W-1:0]   win_reg;
  logic [WIN_W-1:0]   timer_reg;
  logic [IDX_W-1:0]   pair_idx_reg;
  logic [PAIRS-1:0]   resp_reg;
  logic [CNT_W-1:0]   cnt_a_reg, cnt_b_reg;
  logic [1:0]         sync_a_reg, sync_b_reg;
  logic               prev_a_reg, prev_b_reg;
  logic               rise_a, rise_b;
  logic               win_now;
  logic               last_pair;
  logic               last_vote;
  logic               bit_val;
  logic [PAIRS-1:0]   ro_lo, ro_hi;

  assign ro_lo     = ro_in[PAIRS-1:0];
  assign ro_hi     = ro_in[2*PAIRS-1:PAIRS];
  assign rise_a    = sync_a_reg[1] & ~prev_a_reg;
  assign rise_b    = sync_b_reg[1] & ~prev_b_reg;
  assign win_now   = (cnt_a_reg > cnt_b_reg);
  assign last_pair = (pair_idx_reg == IDX_W'(PAIRS - 1));

`ifdef PUF_MAJORITY_EN
  localparam int VW = $clog2(VOTES + 1);
  logic [VW-1:0] vote_idx_reg, wins_reg, wins_total;

  assign wins_total = wins_reg + VW'(win_now);
  assign last_vote  = (vote_idx_reg == VW'(VOTES - 1));
  assign bit_val    = (wins_total > VW'(VOTES / 2));

  // Vote bookkeeping: which evaluation of the current pair, and wins so far
  always_ff @(posedge clk_ref) begin
    if (rst || start_accept) begin
      vote_idx_reg <= '0;
      wins_reg     <= '0;
    end else if (state_reg == S_COMPARE) begin
      if (last_vote) begin
        vote_idx_reg <= '0;
        wins_reg     <= '0;
      end else begin
        vote_idx_reg <= vote_idx_reg + VW'(1);
        wins_reg     <= wins_total;
      end
    end
  end
`else
  assign last_vote = 1'b1;
  assign bit_val   = win_now;
`endif

  // Two-flop synchronisers plus edge-detect history for the selected pair
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      sync_a_reg <= '0;
      sync_b_reg <= '0;
      prev_a_reg <= 1'b0;
      prev_b_reg <= 1'b0;
    end else begin
      sync_a_reg <= {sync_a_reg[0], ro_lo[pair_idx_reg]};
      sync_b_reg <= {sync_b_reg[0], ro_hi[pair_idx_reg]};
      prev_a_reg <= sync_a_reg[1];
      prev_b_reg <= sync_b_reg[1];
    end
  end

  // Shared edge counters: cleared per measurement, saturate instead of wrapping
  always_ff @(posedge clk_ref) begin
    if (rst || state_reg == S_CLEAR) begin
      cnt_a_reg <= '0;
      cnt_b_reg <= '0;
    end else if (state_reg == S_COUNT) begin
      if (rise_a && cnt_a_reg != '1) cnt_a_reg <= cnt_a_reg + CNT_W'(1);
      if (rise_b && cnt_b_reg != '1) cnt_b_reg <= cnt_b_reg + CNT_W'(1);
    end
  end

  // State register
  always_ff @(posedge clk_ref) begin
    if (rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // Next-state decode and status outputs
  always_comb begin
    state_next   = state_reg;
    busy         = 1'b0;
    done         = 1'b0;
    start_accept = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          start_accept = 1'b1;
          state_next   = S_CLEAR;
        end
      end
      S_CLEAR: begin
        busy       = 1'b1;
        state_next = S_SETTLE;
      end
      S_SETTLE: begin
        busy = 1'b1;
        if (timer_reg == '0) state_next = S_COUNT;
      end
      S_COUNT: begin
        busy = 1'b1;
        if (timer_reg == '0) state_next = S_COMPARE;
      end
      S_COMPARE: begin
        busy       = 1'b1;
        state_next = (last_vote && last_pair) ? S_FIN : S_CLEAR;
      end
      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Window latch, phase timer, pair index and response bits
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      win_reg      <= WIN_W'(1);
      timer_reg    <= '0;
      pair_idx_reg <= '0;
      resp_reg     <= '0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            // A zero window would never count; run it as one cycle
            win_reg      <= (window_cycles == '0) ? WIN_W'(1) : window_cycles;
            pair_idx_reg <= '0;
            resp_reg     <= '0;
          end
        end
        S_CLEAR:  timer_reg <= WIN_W'(1);
        S_SETTLE: timer_reg <= (timer_reg == '0) ? win_reg - WIN_W'(1)
                                                 : timer_reg - WIN_W'(1);
        S_COUNT:  timer_reg <= timer_reg - WIN_W'(1);
        S_COMPARE: begin
          if (last_vote) begin
            resp_reg[pair_idx_reg] <= bit_val;
            if (!last_pair) pair_idx_reg <= pair_idx_reg + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign puf_response = resp_reg;
  assign pair_idx     = pair_idx_reg;

endmodule

// File: tb/tb_ro_puf_seq.sv
// Bench for ro_puf_seq: fixed vector table, reset/restart and start-spam
// sequences, then randomised RO waveforms checked against an edge-count model.
module tb_ro_puf_seq;
  localparam int P  = 4;
  localparam int CW = 6;
  localparam int WW = 16;
`ifdef PUF_MAJORITY_EN
  localparam int NV = 3;
`else
  localparam int NV = 1;
`endif
  localparam int SAT = (1 << CW) - 1;

  logic          clk_ref = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [2*P-1:0] ro_in = '0;
  logic [WW-1:0] window_cycles = '0;
  logic          busy, done;
  logic [P-1:0]  puf_response;
  logic [1:0]    pair_idx;

  ro_puf_seq #(.PAIRS(P), .CNT_W(CW), .WIN_W(WW), .VOTES(3)) dut (
    .clk_ref(clk_ref), .rst(rst), .start(start), .ro_in(ro_in),
    .window_cycles(window_cycles), .busy(busy), .done(done),
    .puf_response(puf_response), .pair_idx(pair_idx)
  );

  always #5 clk_ref = ~clk_ref;

  int cyc = 0;
  always @(posedge clk_ref) cyc <= cyc + 1;

  // RO waveform generator: square waves of per-RO period/phase, history kept
  int per [2*P];
  int ph  [2*P];
  logic [2*P-1:0] hist [0:65535];
  initial for (int r = 0; r < 2*P; r++) begin per[r] = 8; ph[r] = 0; end
  always @(negedge clk_ref) begin
    for (int r = 0; r < 2*P; r++)
      ro_in[r] = ((cyc + ph[r]) % per[r]) < (per[r] / 2);
    hist[cyc & 65535] = ro_in;
  end

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  function automatic int exp_latency(input int win);
    int w;
    w = (win == 0) ? 1 : win;
    return 1 + P * NV * (w + 4);
  endfunction

  // Reference: pair k, vote v occupies a (W+4)-cycle slot starting the cycle
  // after the start cycle t; its counting window is the last W cycles before
  // the compare cycle. Edges reach the counter two cycles after they appear.
  function automatic logic [P-1:0] model(input int t, input int win);
    logic [P-1:0] res;
    int w, base, ca, cb, wins;
    logic [2*P-1:0] h2, h3;
    w = (win == 0) ? 1 : win;
    res = '0;
    for (int k = 0; k < P; k++) begin
      wins = 0;
      for (int v = 0; v < NV; v++) begin
        base = t + 1 + (k * NV + v) * (w + 4) + 3;
        ca = 0; cb = 0;
        for (int c = base; c < base + w; c++) begin
          h2 = hist[(c - 2) & 65535];
          h3 = hist[(c - 3) & 65535];
          if (h2[k] && !h3[k]) ca++;
          if (h2[k+P] && !h3[k+P]) cb++;
        end
        if (ca > SAT) ca = SAT;
        if (cb > SAT) cb = SAT;
        if (ca > cb) wins++;
      end
      res[k] = (wins > NV / 2);
    end
    return res;
  endfunction

  // One evaluation: start at a negedge, observe until done plus a few cycles
  task automatic run_eval(input int win, input bit hold, input bit sw,
                          output int t, output int lat, output int bcnt,
                          output int dcnt);
    int el;
    el = exp_latency(win);
    @(negedge clk_ref);
    start = 1'b1;
    window_cycles = WW'(win);
    t = cyc; lat = -1; bcnt = 0; dcnt = 0;
    for (int n = 1; n <= 30000; n++) begin
      @(negedge clk_ref);
      start = hold && (n < el - 2);
      window_cycles = WW'($urandom);
      if (sw && $urandom_range(0, 47) == 0)
        per[$urandom_range(0, 2*P-1)] = $urandom_range(4, 14);
      if (busy) bcnt++;
      if (done) begin
        dcnt++;
        if (lat < 0) lat = cyc - t;
      end
      if (lat >= 0 && cyc - t >= lat + 3) break;
    end
    start = 1'b0;
  endtask

  task automatic set_pairs(input int pa0, input int pa1, input int pa2, input int pa3,
                           input int pb0, input int pb1, input int pb2, input int pb3);
    per[0] = pa0; per[1] = pa1; per[2] = pa2; per[3] = pa3;
    per[4] = pb0; per[5] = pb1; per[6] = pb2; per[7] = pb3;
    for (int r = 0; r < 2*P; r++) ph[r] = 0;
  endtask

  typedef struct {
    int pa [P];
    int pb [P];
    int win;
    logic [P-1:0] exp_resp;
  } vec_t;

  vec_t vecs [5];
  int t, lat, bcnt, dcnt, target;
  logic [P-1:0] exp_r;

  initial begin
    vecs[0] = '{pa: '{4, 6, 6, 6}, pb: '{6, 4, 4, 4}, win: 100, exp_resp: 4'b0001};
    vecs[1] = '{pa: '{8, 8, 8, 8}, pb: '{8, 8, 8, 8}, win: 64,  exp_resp: 4'b0000};
    vecs[2] = '{pa: '{4, 4, 4, 4}, pb: '{5, 5, 5, 5}, win: 400, exp_resp: 4'b0000};
    vecs[3] = '{pa: '{5, 4, 5, 4}, pb: '{4, 5, 4, 5}, win: 50,  exp_resp: 4'b1010};
    vecs[4] = '{pa: '{8, 8, 8, 8}, pb: '{8, 8, 8, 8}, win: 0,   exp_resp: 4'b0000};

    // Reset state
    rst = 1'b1;
    repeat (3) @(negedge clk_ref);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_resp", int'(puf_response), 0);
    check("rst_pair_idx", int'(pair_idx), 0);
    rst = 1'b0;
    @(negedge clk_ref);

    // Table vectors
    for (int i = 0; i < 5; i++) begin
      set_pairs(vecs[i].pa[0], vecs[i].pa[1], vecs[i].pa[2], vecs[i].pa[3],
                vecs[i].pb[0], vecs[i].pb[1], vecs[i].pb[2], vecs[i].pb[3]);
      run_eval(vecs[i].win, 1'b0, 1'b0, t, lat, bcnt, dcnt);
      $display("vec %0d win=%0d resp=%b lat=%0d busy=%0d", i, vecs[i].win,
               puf_response, lat, bcnt);
      check($sformatf("vec%0d_resp", i), int'(puf_response), int'(vecs[i].exp_resp));
      check($sformatf("vec%0d_latency", i), lat, exp_latency(vecs[i].win));
      check($sformatf("vec%0d_busy_cycles", i), bcnt, exp_latency(vecs[i].win) - 1);
      check($sformatf("vec%0d_done_pulses", i), dcnt, 1);
    end

    // Reset in the middle of pair 2's count window, then a clean restart
    set_pairs(4, 8, 8, 8, 8, 8, 8, 8);
    @(negedge clk_ref);
    start = 1'b1; window_cycles = 16'd20; t = cyc;
    @(negedge clk_ref);
    start = 1'b0;
    target = t + 1 + 2 * NV * 24 + 8;
    while (cyc < target) @(negedge clk_ref);
    check("midrst_pre_pair_idx", int'(pair_idx), 2);
    check("midrst_pre_bit0", int'(puf_response[0]), 1);
    rst = 1'b1;
    @(negedge clk_ref);
    $display("midrst busy=%b done=%b resp=%b pair_idx=%0d", busy, done, puf_response, pair_idx);
    check("midrst_busy", int'(busy), 0);
    check("midrst_done", int'(done), 0);
    check("midrst_resp", int'(puf_response), 0);
    check("midrst_pair_idx", int'(pair_idx), 0);
    rst = 1'b0;
    run_eval(20, 1'b0, 1'b0, t, lat, bcnt, dcnt);
    $display("restart resp=%b lat=%0d", puf_response, lat);
    check("restart_resp", int'(puf_response), 1);
    check("restart_latency", lat, exp_latency(20));

    // start held high and window changing throughout the run
    set_pairs(4, 6, 6, 6, 6, 4, 4, 4);
    run_eval(30, 1'b1, 1'b0, t, lat, bcnt, dcnt);
    $display("startspam resp=%b lat=%0d dones=%0d", puf_response, lat, dcnt);
    check("startspam_latency", lat, exp_latency(30));
    check("startspam_done_pulses", dcnt, 1);
    check("startspam_resp", int'(puf_response), 1);

    // Randomised waveforms, periods occasionally switching mid-run
    for (int i = 0; i < 12; i++) begin
      int win;
      for (int r = 0; r < 2*P; r++) begin
        per[r] = $urandom_range(4, 14);
        ph[r]  = $urandom_range(0, 13);
      end
      win = $urandom_range(0, 200);
      run_eval(win, 1'b0, 1'b1, t, lat, bcnt, dcnt);
      exp_r = model(t, win);
      $display("rand %0d win=%0d resp=%b model=%b lat=%0d", i, win, puf_response, exp_r, lat);
      check($sformatf("rand%0d_resp", i), int'(puf_response), int'(exp_r));
      check($sformatf("rand%0d_latency", i), lat, exp_latency(win));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
